// File: rtl/cnt_pkg.sv
// Shared types and helpers for the shared delay-counter arbiter.
// Holds the FSM state type, default sizes and the round-robin pick.
package cnt_pkg;

  localparam int CNT_W_DEF = 8;
  localparam int N_REQ_DEF = 4;
  localparam int RR_MAX    = 16;

  typedef enum logic {
    IDLE,
    RUN
  } arb_state_t;

  typedef struct packed {
    logic       vld;
    logic [3:0] idx;
  } rr_pick_t;

  // First set bit of eligible, searching ptr, ptr+1, ... with wrap at n.
  // Walks the distances from far to near so the nearest hit wins.
  function automatic rr_pick_t rr_pick(
    input logic [RR_MAX-1:0] eligible,
    input logic [3:0]        ptr,
    input int                n
  );
    rr_pick_t r;
    int       j;
    r = '0;
    for (int k = RR_MAX - 1; k >= 0; k--) begin
      if (k < n) begin
        j = int'(ptr) + k;
        if (j >= n) j = j - n;
        if (eligible[j[3:0]]) begin
          r.vld = 1'b1;
          r.idx = j[3:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/cnt_clr.sv
// Up-counter with synchronous clear (priority) and count enable.
// Ports: Clk, resetn (async low), clr, en -> q[W-1:0].
module cnt_clr
  import cnt_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         Clk,
  input  logic         resetn,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/cnt_delay_arb.sv
// Round-robin arbiter sharing one delay counter among N_REQ clients.
// Ports: Clk, resetn, req, len -> gnt, done, busy, cnt_q.
module cnt_delay_arb
  import cnt_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int W     = CNT_W_DEF
) (
  input  logic             Clk,
  input  logic             resetn,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ*W-1:0] len,
  output logic [N_REQ-1:0] gnt,
  output logic [N_REQ-1:0] done,
  output logic             busy,
  output logic [W-1:0]     cnt_q
);

  arb_state_t        state_q;
  logic [3:0]        ptr_q;
  logic [N_REQ-1:0]  mask_q;
  logic [N_REQ-1:0]  gnt_q;
  logic [W-1:0]      len_lat;
  logic [RR_MAX-1:0] elig;
  rr_pick_t          pick;
  logic              run;
  logic              match;
  logic              alive;
  logic              grant;
  logic [4:0]        nxt;
  logic [3:0]        ptr_nxt;

  assign elig  = RR_MAX'(req & ~mask_q);
  assign pick  = rr_pick(elig, ptr_q, N_REQ);
  assign run   = (state_q == RUN);
  assign match = (cnt_q == len_lat);
  // Granted client still requesting; low means abort.
  assign alive = |(req & gnt_q);
  assign grant = !run && pick.vld;

  assign nxt     = {1'b0, pick.idx} + 5'd1;
  assign ptr_nxt = (nxt == 5'(N_REQ)) ? 4'd0 : nxt[3:0];

  // Abort beats match: a dropped req masks the done bit.
  assign done = (run && match) ? (gnt_q & req) : '0;
  assign gnt  = gnt_q;
  assign busy = run;

  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      mask_q  <= '0;
      len_lat <= '0;
    end else begin
      // Serviced bit sticks until the client drops req.
      mask_q <= (mask_q & req) | done;
      if (grant) begin
        state_q <= RUN;
        gnt_q   <= N_REQ'(1) << pick.idx;
        len_lat <= len[int'(pick.idx)*W +: W];
        ptr_q   <= ptr_nxt;
      end else if (run && (!alive || match)) begin
        state_q <= IDLE;
        gnt_q   <= '0;
      end
    end
  end

  cnt_clr #(
    .W(W)
  ) u_cnt (
    .Clk    (Clk),
    .resetn (resetn),
    .clr    (grant),
    .en     (run && !match),
    .q      (cnt_q)
  );

endmodule
